// File: rtl/hist_pkg.sv
// Shared types and helpers for the parametrised histogram engine.
package hist_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } hist_state_e;

  // Bin index is the top bin_w bits of the sample, giving uniform-width bins.
  function automatic int unsigned bin_of(input logic [63:0] data,
                                         input int unsigned data_w,
                                         input int unsigned bin_w);
    return 32'((data >> (data_w - bin_w)) & ((64'd1 << bin_w) - 64'd1));
  endfunction

  function automatic logic [63:0] count_max(input int unsigned w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

endpackage

// File: rtl/hist_dpram.sv
// Simple dual-port RAM: port A write plus synchronous read, port B read-only.
// Both reads are read-first with respect to a same-edge write.
module hist_dpram
  import hist_pkg::*;
#(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] waddr_a,
  input  logic [DATA_W-1:0] din_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] q_a,
  input  logic              re_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] q_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[waddr_a] <= din_a;
  end

  always_ff @(posedge clk) begin
    q_a <= mem[raddr_a];
  end

  always_ff @(posedge clk) begin
    if (rst)       q_b <= '0;
    else if (re_b) q_b <= mem[raddr_b];
  end

endmodule

// File: rtl/histogram_engine_param.sv
// Parametrised histogram engine: 3-stage RMW pipeline with same-bin forwarding.
// Define HIST_MINMAX_EN to build running min/max tracking of accepted samples.
module histogram_engine_param
  import hist_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_BINS = 8,
  parameter int unsigned COUNT_W  = 16,
  parameter int unsigned BIN_W    = $clog2(NUM_BINS)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               clear_req,
  output logic               busy,
  input  logic               rd_en,
  input  logic [BIN_W-1:0]   rd_addr,
  output logic [COUNT_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               sat_flag,
  output logic [DATA_W-1:0]  min_val,
  output logic [DATA_W-1:0]  max_val
);

  localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(count_max(COUNT_W));

  hist_state_e        state, state_nxt;
  logic [BIN_W-1:0]   clr_cnt;
  logic               accept;
  logic               p1_valid, p2_valid, fwd_hit;
  logic [BIN_W-1:0]   p1_bin, p2_bin;
  logic [COUNT_W-1:0] ram_q, fwd_data, base_cnt, new_cnt;
  logic               wr_en;
  logic [BIN_W-1:0]   wr_addr;
  logic [COUNT_W-1:0] wr_data;

  assign s_ready = (state == RUN);
  assign busy    = (state == CLEAR);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge aclk) begin
    if (areset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = p2_bin;
    wr_data   = new_cnt;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = '0;
        if (!clear_req && clr_cnt == '1) state_nxt = RUN;
      end
      RUN: begin
        wr_en = p2_valid && !clear_req;
        if (clear_req) state_nxt = CLEAR;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset || clear_req || state == RUN) clr_cnt <= '0;
    else                                     clr_cnt <= clr_cnt + BIN_W'(1);
  end

  // The RAM read at the same edge as the previous write returns the stale count,
  // so the value being written is captured and substituted one stage later.
  assign base_cnt = fwd_hit ? fwd_data : ram_q;
  assign new_cnt  = (base_cnt == CNT_MAX) ? base_cnt : base_cnt + COUNT_W'(1);

  always_ff @(posedge aclk) begin
    if (areset || clear_req) begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      fwd_hit  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      p1_valid <= accept;
      p2_valid <= p1_valid;
      fwd_hit  <= p1_valid && p2_valid && (p1_bin == p2_bin);
      if (p2_valid && new_cnt == CNT_MAX) sat_flag <= 1'b1;
    end
    p1_bin   <= BIN_W'(bin_of(64'(s_data), DATA_W, BIN_W));
    p2_bin   <= p1_bin;
    fwd_data <= new_cnt;
  end

  always_ff @(posedge aclk) begin
    if (areset) rd_valid <= 1'b0;
    else        rd_valid <= rd_en;
  end

  hist_dpram #(
    .ADDR_W(BIN_W),
    .DATA_W(COUNT_W)
  ) u_ram (
    .clk    (aclk),
    .rst    (areset),
    .we_a   (wr_en),
    .waddr_a(wr_addr),
    .din_a  (wr_data),
    .raddr_a(p1_bin),
    .q_a    (ram_q),
    .re_b   (rd_en),
    .raddr_b(rd_addr),
    .q_b    (rd_data)
  );

`ifdef HIST_MINMAX_EN
  logic [DATA_W-1:0] min_q, max_q;

  always_ff @(posedge aclk) begin
    if (areset || clear_req) begin
      min_q <= '1;
      max_q <= '0;
    end else if (accept) begin
      if (s_data < min_q) min_q <= s_data;
      if (s_data > max_q) max_q <= s_data;
    end
  end

  assign min_val = min_q;
  assign max_val = max_q;
`else
  assign min_val = '0;
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_histogram_engine_param.sv
// Directed scoreboard bench for histogram_engine_param (DATA_W=8, NUM_BINS=8, COUNT_W=8).
module tb_histogram_engine_param;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_BINS = 8;
  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned BIN_W    = 3;

  logic               aclk = 1'b0;
  logic               areset = 1'b1;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data = '0;
  logic               clear_req = 1'b0;
  logic               busy;
  logic               rd_en = 1'b0;
  logic [BIN_W-1:0]   rd_addr = '0;
  logic [COUNT_W-1:0] rd_data;
  logic               rd_valid;
  logic               sat_flag;
  logic [DATA_W-1:0]  min_val;
  logic [DATA_W-1:0]  max_val;

  histogram_engine_param #(
    .DATA_W  (DATA_W),
    .NUM_BINS(NUM_BINS),
    .COUNT_W (COUNT_W)
  ) dut (
    .aclk     (aclk),
    .areset   (areset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .clear_req(clear_req),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .sat_flag (sat_flag),
    .min_val  (min_val),
    .max_val  (max_val)
  );

  always #5 aclk = ~aclk;

  int compared   = 0;
  int mismatched = 0;
  logic [COUNT_W-1:0] exp_q[$];
  int                 addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Readout monitor: every rd_valid pulse must match the oldest queued request.
  always @(negedge aclk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rd_valid: got rd_data %0h expected no readout", rd_data);
      end else begin
        logic [COUNT_W-1:0] e;
        int a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        check($sformatf("bin%0d", a), 32'(rd_data), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic read_bin(input int a, input logic [COUNT_W-1:0] e);
    rd_en   = 1'b1;
    rd_addr = BIN_W'(a);
    exp_q.push_back(e);
    addr_q.push_back(a);
    tick();
    rd_en = 1'b0;
  endtask

  // Expected counts packed bin7..bin0, one byte each.
  task automatic read_all(input logic [63:0] e);
    repeat (4) tick();
    for (int i = 0; i < 8; i++) read_bin(i, e[8*i +: 8]);
    repeat (2) tick();
  endtask

  task automatic wait_clear(input string name);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 50) begin
      cnt++;
      tick();
    end
    check(name, 32'(cnt), 32'd8);
    check({name, "_ready"}, 32'(s_ready), 32'd1);
  endtask

  task automatic do_clear(input string name);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    wait_clear(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) tick();
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
`ifdef HIST_MINMAX_EN
    check("rst_min", 32'(min_val), 32'hFF);
    check("rst_max", 32'(max_val), 32'h00);
`else
    check("tied_min", 32'(min_val), 32'h00);
    check("tied_max", 32'(max_val), 32'h00);
`endif
    areset = 1'b0;
    wait_clear("reset_busy_cycles");
    read_all(64'h0000_0000_0000_0000);

    // Spaced samples across three bins.
    send(8'h05); tick();
    send(8'h25); tick(); tick();
    send(8'hFF);
    read_all(64'h0100_0000_0000_0101);

    // Back-to-back same-bin samples rely on forwarding; read 3 edges after the last.
    repeat (4) send(8'h40);
    tick(); tick();
    read_bin(2, 8'd4);
    repeat (3) tick();

    do_clear("clear1_busy_cycles");
    check("clear1_sat", 32'(sat_flag), 32'd0);
    repeat (300) send(8'h80);
    read_all(64'h0000_00FF_0000_0000);
    check("sat_set", 32'(sat_flag), 32'd1);

    // Two samples in flight when clear_req arrives must vanish.
    send(8'h20);
    send(8'h20);
    do_clear("clear2_busy_cycles");
    check("clear2_sat", 32'(sat_flag), 32'd0);
    read_all(64'h0000_0000_0000_0000);
    send(8'h20);
    tick(); tick();
    read_bin(1, 8'd1);

    // Read-first: readout at the write edge sees the old count, next edge the new.
    send(8'h60);
    tick();
    read_bin(3, 8'd0);
    read_bin(3, 8'd1);
    repeat (3) tick();

`ifdef HIST_MINMAX_EN
    do_clear("clear3_busy_cycles");
    check("mm_clr_min", 32'(min_val), 32'hFF);
    check("mm_clr_max", 32'(max_val), 32'h00);
    send(8'h30);
    send(8'h10);
    send(8'hE0);
    tick();
    check("mm_min", 32'(min_val), 32'h10);
    check("mm_max", 32'(max_val), 32'hE0);
    do_clear("clear4_busy_cycles");
    check("mm_after_min", 32'(min_val), 32'hFF);
    check("mm_after_max", 32'(max_val), 32'h00);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL readout_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
